// File: rtl/mips_bus_pkg.sv
// ----------------------------------------------------------------------------
// mips_bus_pkg
// Shared types and constants for the mips_cpu_bus arbiter.
//   arb_state_t : arbiter FSM states (idle, fetch owns bus, data owns bus)
//   grant_t     : which requester was granted (fetch or data port)
//   BUS_W       : bus address/data width
//   BE_WORD     : full-word lane enables used by instruction fetches
// ----------------------------------------------------------------------------
package mips_bus_pkg;

    localparam int         BUS_W   = 32;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

endpackage

// File: rtl/mips_bus_rr_pick.sv
// ----------------------------------------------------------------------------
// mips_bus_rr_pick
// Combinational two-way round-robin select between the fetch and data ports.
// Ports:
//   i_if_req      in   fetch port request level
//   i_dm_req      in   data port request level
//   i_last_grant  in   port that won the previous arbitration
//   o_valid       out  at least one request pending
//   o_grant       out  selected port (meaningful only when o_valid=1)
// ----------------------------------------------------------------------------
module mips_bus_rr_pick
    import mips_bus_pkg::*;
(
    input  logic   i_if_req,
    input  logic   i_dm_req,
    input  grant_t i_last_grant,
    output logic   o_valid,
    output grant_t o_grant
);

    always_comb begin
        o_valid = i_if_req | i_dm_req;
        o_grant = GNT_FETCH;
        if (i_if_req && i_dm_req) begin
            // Contention: the port that did not win last time goes first.
            o_grant = (i_last_grant == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
        end else if (i_dm_req) begin
            o_grant = GNT_DATA;
        end
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mips_bus_arbiter
// Shares the single mips_cpu_bus memory bus between the instruction-fetch
// port and the data port. One transaction at a time; all bus outputs are
// registered and held stable while waitrequest=1. The owning requester gets
// a one-cycle done pulse after the accept edge, with read data captured in
// resp_rdata for reads.
//
// Optional feature (compile-time macro MIPS_BUS_ARB_TIMEOUT_EN):
//   a wait counter aborts a transaction after TIMEOUT_CYCLES stalled cycles,
//   pulsing bus_err together with the owner's done. Without the macro a
//   transaction waits indefinitely and bus_err is tied to 0.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   if_req, if_addr, if_done   fetch port (level request, done pulse)
//   dm_req, dm_write, dm_addr, dm_wdata, dm_byteenable, dm_done   data port
//   resp_rdata                 last completed read data
//   address, write, read, writedata, byteenable   bus master outputs
//   waitrequest, readdata      bus slave inputs
//   bus_err                    timeout abort pulse
// ----------------------------------------------------------------------------
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req,
    input  logic [BUS_W-1:0] if_addr,
    output logic             if_done,
    input  logic             dm_req,
    input  logic             dm_write,
    input  logic [BUS_W-1:0] dm_addr,
    input  logic [BUS_W-1:0] dm_wdata,
    input  logic [3:0]       dm_byteenable,
    output logic             dm_done,
    output logic [BUS_W-1:0] resp_rdata,
    output logic [BUS_W-1:0] address,
    output logic             write,
    output logic             read,
    input  logic             waitrequest,
    output logic [BUS_W-1:0] writedata,
    output logic [3:0]       byteenable,
    input  logic [BUS_W-1:0] readdata,
    output logic             bus_err
);

    // ------------------------------------------------------------------
    // State and bus registers
    // ------------------------------------------------------------------
    arb_state_t       r_state;
    grant_t           r_last_grant;
    logic [BUS_W-1:0] r_address;
    logic             r_read;
    logic             r_write;
    logic [BUS_W-1:0] r_writedata;
    logic [3:0]       r_byteenable;
    logic [BUS_W-1:0] r_resp_rdata;
    logic             r_if_done;
    logic             r_dm_done;

    arb_state_t       w_state_nxt;
    grant_t           w_last_grant_nxt;
    logic [BUS_W-1:0] w_address_nxt;
    logic             w_read_nxt;
    logic             w_write_nxt;
    logic [BUS_W-1:0] w_writedata_nxt;
    logic [3:0]       w_byteenable_nxt;
    logic [BUS_W-1:0] w_resp_rdata_nxt;
    logic             w_if_done_nxt;
    logic             w_dm_done_nxt;

    logic             w_pick_valid;
    grant_t           w_pick_grant;

`ifdef MIPS_BUS_ARB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_cnt_nxt;
    logic              r_bus_err;
    logic              w_bus_err_nxt;
`endif

    mips_bus_rr_pick u_rr_pick (
        .i_if_req     (if_req),
        .i_dm_req     (dm_req),
        .i_last_grant (r_last_grant),
        .o_valid      (w_pick_valid),
        .o_grant      (w_pick_grant)
    );

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_address_nxt    = r_address;
        w_read_nxt       = r_read;
        w_write_nxt      = r_write;
        w_writedata_nxt  = r_writedata;
        w_byteenable_nxt = r_byteenable;
        w_resp_rdata_nxt = r_resp_rdata;
        w_if_done_nxt    = 1'b0;
        w_dm_done_nxt    = 1'b0;
`ifdef MIPS_BUS_ARB_TIMEOUT_EN
        w_wait_cnt_nxt   = r_wait_cnt;
        w_bus_err_nxt    = 1'b0;
`endif

        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_last_grant_nxt = w_pick_grant;
`ifdef MIPS_BUS_ARB_TIMEOUT_EN
                    w_wait_cnt_nxt   = '0;
`endif
                    if (w_pick_grant == GNT_FETCH) begin
                        w_state_nxt      = ST_FETCH;
                        w_address_nxt    = if_addr;
                        w_read_nxt       = 1'b1;
                        w_write_nxt      = 1'b0;
                        w_byteenable_nxt = BE_WORD;
                        w_writedata_nxt  = '0;
                    end else begin
                        w_state_nxt      = ST_DATA;
                        w_address_nxt    = dm_addr;
                        w_read_nxt       = ~dm_write;
                        w_write_nxt      = dm_write;
                        w_byteenable_nxt = dm_byteenable;
                        w_writedata_nxt  = dm_wdata;
                    end
                end
            end

            ST_FETCH, ST_DATA: begin
                if (!waitrequest) begin
                    // Accept edge: only reads update the response register.
                    if (r_read) begin
                        w_resp_rdata_nxt = readdata;
                    end
                    w_read_nxt    = 1'b0;
                    w_write_nxt   = 1'b0;
                    w_if_done_nxt = (r_state == ST_FETCH);
                    w_dm_done_nxt = (r_state == ST_DATA);
                    w_state_nxt   = ST_IDLE;
                end
`ifdef MIPS_BUS_ARB_TIMEOUT_EN
                // The edge that would make the count reach TIMEOUT_CYCLES
                // aborts instead; a timed-out read reports zero data.
                else if (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    if (r_read) begin
                        w_resp_rdata_nxt = '0;
                    end
                    w_read_nxt    = 1'b0;
                    w_write_nxt   = 1'b0;
                    w_if_done_nxt = (r_state == ST_FETCH);
                    w_dm_done_nxt = (r_state == ST_DATA);
                    w_bus_err_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
`endif
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_read_nxt  = 1'b0;
                w_write_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GNT_DATA;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Bus and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_address    <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_writedata  <= '0;
            r_byteenable <= '0;
            r_resp_rdata <= '0;
            r_if_done    <= 1'b0;
            r_dm_done    <= 1'b0;
        end else begin
            r_address    <= w_address_nxt;
            r_read       <= w_read_nxt;
            r_write      <= w_write_nxt;
            r_writedata  <= w_writedata_nxt;
            r_byteenable <= w_byteenable_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_if_done    <= w_if_done_nxt;
            r_dm_done    <= w_dm_done_nxt;
        end
    end

`ifdef MIPS_BUS_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
            r_bus_err  <= w_bus_err_nxt;
        end
    end

    assign bus_err = r_bus_err;
`else
    assign bus_err = 1'b0;
`endif

    assign address    = r_address;
    assign read       = r_read;
    assign write      = r_write;
    assign writedata  = r_writedata;
    assign byteenable = r_byteenable;
    assign resp_rdata = r_resp_rdata;
    assign if_done    = r_if_done;
    assign dm_done    = r_dm_done;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mips_bus_arbiter
// Self-checking bench for mips_bus_arbiter. Expected transactions are pushed
// to exp_q when a request is driven; a negedge monitor pushes the observed
// transaction (bus fields at the accept cycle plus resp_rdata) to act_q on
// every done pulse. Build with +define+MIPS_BUS_ARB_TIMEOUT_EN to add the
// timeout scenario.
// ----------------------------------------------------------------------------
module tb_mips_bus_arbiter;

    localparam int         EW             = 102;
    localparam logic [1:0] K_FETCH        = 2'd0;
    localparam logic [1:0] K_LOAD         = 2'd1;
    localparam logic [1:0] K_STORE        = 2'd2;
    localparam int         TIMEOUT_CYCLES = 16;
`ifdef MIPS_BUS_ARB_TIMEOUT_EN
    localparam int         MID_STALL      = 5;
`else
    localparam int         MID_STALL      = 20;
`endif

    // ------------------------------------------------------------------
    // Clock / reset and DUT signals
    // ------------------------------------------------------------------
    logic        clk           = 1'b0;
    logic        reset         = 1'b1;
    logic        if_req        = 1'b0;
    logic [31:0] if_addr       = '0;
    logic        if_done;
    logic        dm_req        = 1'b0;
    logic        dm_write      = 1'b0;
    logic [31:0] dm_addr       = '0;
    logic [31:0] dm_wdata      = '0;
    logic [3:0]  dm_byteenable = '0;
    logic        dm_done;
    logic [31:0] resp_rdata;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest   = 1'b0;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata      = '0;
    logic        bus_err;

    always #5 clk = ~clk;

    mips_bus_arbiter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk           (clk),
        .reset         (reset),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_done       (if_done),
        .dm_req        (dm_req),
        .dm_write      (dm_write),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_byteenable (dm_byteenable),
        .dm_done       (dm_done),
        .resp_rdata    (resp_rdata),
        .address       (address),
        .write         (write),
        .read          (read),
        .waitrequest   (waitrequest),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .bus_err       (bus_err)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] act_q[$];
    logic [31:0]   model_resp = '0;
    int            n_checks   = 0;
    int            n_pass     = 0;

    function automatic logic [EW-1:0] pack_txn(input logic [1:0] k, input logic [31:0] a,
                                               input logic [31:0] wd, input logic [3:0] be,
                                               input logic [31:0] rd);
        return {k, a, wd, be, rd};
    endfunction

    // ------------------------------------------------------------------
    // Bus slave: stalls each transfer for stall_target cycles
    // ------------------------------------------------------------------
    int stall_target = 0;
    int stall_cnt    = 0;

    always @(negedge clk) begin
        if (reset || !(read || write)) begin
            waitrequest = 1'b0;
            stall_cnt   = 0;
        end else if (stall_cnt < stall_target) begin
            waitrequest = 1'b1;
            stall_cnt++;
        end else begin
            waitrequest = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: snapshots bus fields while strobes are up, records a
    // transaction on each done pulse, counts protocol violations.
    // ------------------------------------------------------------------
    logic [31:0] s_addr   = '0;
    logic [31:0] s_wdata  = '0;
    logic [3:0]  s_be     = '0;
    logic        s_read   = 1'b0;
    logic        s_write  = 1'b0;
    logic        prev_strobe  = 1'b0;
    logic        prev_if_done = 1'b0;
    logic        prev_dm_done = 1'b0;
    int          done_cnt      = 0;
    int          rw_err        = 0;
    int          both_done_err = 0;
    int          width_err     = 0;
    int          stable_err    = 0;

    always @(negedge clk) begin
        if (reset) begin
            prev_strobe  = 1'b0;
            prev_if_done = 1'b0;
            prev_dm_done = 1'b0;
        end else begin
            if (read && write) rw_err++;
            if (if_done && dm_done) both_done_err++;
            if ((if_done && prev_if_done) || (dm_done && prev_dm_done)) width_err++;
            if (read || write) begin
                if (prev_strobe && (address !== s_addr || read !== s_read || write !== s_write ||
                                    byteenable !== s_be || writedata !== s_wdata))
                    stable_err++;
                s_addr  = address;
                s_read  = read;
                s_write = write;
                s_be    = byteenable;
                s_wdata = writedata;
            end
            if (if_done || dm_done) begin
                done_cnt++;
                act_q.push_back(pack_txn(if_done ? K_FETCH : (s_write ? K_STORE : K_LOAD),
                                         s_addr, s_wdata, s_be, resp_rdata));
            end
            prev_strobe  = read || write;
            prev_if_done = if_done;
            prev_dm_done = dm_done;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset  = 1'b1;
        if_req = 1'b0;
        dm_req = 1'b0;
        step();
        step();
        reset      = 1'b0;
        model_resp = '0;
        step();
    endtask

    // Waits (bounded) for a done pulse; counts strobe and idle cycles seen first.
    task automatic wait_done(input int max_cyc, output bit seen, output int sc, output int ic);
        seen = 1'b0;
        sc   = 0;
        ic   = 0;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (if_done || dm_done) begin
                seen = 1'b1;
                break;
            end else if (read || write) begin
                sc++;
            end else begin
                ic++;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [134:0] outs;
        reset = 1'b1;
        step();
        outs = {address, read, write, writedata, byteenable, resp_rdata, if_done, dm_done, bus_err};
        n_checks++;
        if (outs !== '0) $display("FAIL reset_outputs: got %h expected all zero", outs);
        else n_pass++;
        reset = 1'b0;
        step();
        step();
        n_checks++;
        if ({read, write, if_done, dm_done} !== 4'b0000)
            $display("FAIL idle_quiet: got r/w/ifd/dmd=%b expected 0000", {read, write, if_done, dm_done});
        else n_pass++;
    endtask

    task automatic test_fetch_no_wait();
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        stall_target = 0;
        readdata     = 32'h3C03_BFC0;
        if_addr      = 32'hBFC0_0000;
        if_req       = 1'b1;
        exp_q.push_back(pack_txn(K_FETCH, 32'hBFC0_0000, 32'h0, 4'hF, 32'h3C03_BFC0));
        model_resp = 32'h3C03_BFC0;
        step();
        n_checks++;
        if (!(read === 1'b1 && write === 1'b0 && address === 32'hBFC0_0000 &&
              byteenable === 4'hF && if_done === 1'b0))
            $display("FAIL fetch_strobe: got r=%b w=%b a=%h be=%b d=%b expected r=1 w=0 a=bfc00000 be=1111 d=0",
                     read, write, address, byteenable, if_done);
        else n_pass++;
        step();
        n_checks++;
        if (!(if_done === 1'b1 && read === 1'b0 && resp_rdata === 32'h3C03_BFC0))
            $display("FAIL fetch_done: got d=%b r=%b rdata=%h expected d=1 r=0 rdata=3c03bfc0",
                     if_done, read, resp_rdata);
        else n_pass++;
        if_req = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (act_q.size() == 0) $display("FAIL sb_fetch: got nothing expected %h", e);
            else begin
                a = act_q.pop_front();
                if (a !== e) $display("FAIL sb_fetch: got %h expected %h", a, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_wait_states();
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        logic [31:0]   addr;
        logic [31:0]   rd;
        bit            seen;
        int            sc;
        int            ic;
        int            d0;
        addr         = $urandom() & 32'hFFFF_FFFC;
        rd           = $urandom();
        stall_target = 3;
        readdata     = rd;
        if_addr      = addr;
        if_req       = 1'b1;
        exp_q.push_back(pack_txn(K_FETCH, addr, 32'h0, 4'hF, rd));
        model_resp = rd;
        d0 = done_cnt;
        wait_done(20, seen, sc, ic);
        if_req = 1'b0;
        n_checks++;
        if (!(seen && sc == 4 && ic == 0))
            $display("FAIL wait_strobe_len: got seen=%0d strobes=%0d idle=%0d expected seen=1 strobes=4 idle=0",
                     seen, sc, ic);
        else n_pass++;
        n_checks++;
        if (stable_err != 0) $display("FAIL wait_stable: got %0d changes expected 0", stable_err);
        else n_pass++;
        step();
        step();
        step();
        n_checks++;
        if (done_cnt - d0 != 1) $display("FAIL wait_done_once: got %0d pulses expected 1", done_cnt - d0);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (act_q.size() == 0) $display("FAIL sb_wait: got nothing expected %h", e);
            else begin
                a = act_q.pop_front();
                if (a !== e) $display("FAIL sb_wait: got %h expected %h", a, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        logic [31:0]   rd[5];
        logic [31:0]   fa;
        logic [31:0]   da;
        logic [31:0]   wd;
        logic [3:0]    be;
        bit            seen;
        int            sc;
        int            ic;
        apply_reset();
        foreach (rd[k]) rd[k] = $urandom();
        fa = ($urandom() & 32'h0FFF_FFFC) | 32'h1000_0000;
        da = ($urandom() & 32'h0FFF_FFFC) | 32'h2000_0000;
        wd = $urandom();
        be = 4'($urandom_range(1, 15));
        stall_target  = 0;
        if_addr       = fa;
        dm_addr       = da;
        dm_write      = 1'b0;
        dm_wdata      = wd;
        dm_byteenable = be;
        readdata      = rd[0];
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) exp_q.push_back(pack_txn(K_FETCH, fa, 32'h0, 4'hF, rd[k]));
            else            exp_q.push_back(pack_txn(K_LOAD, da, wd, be, rd[k]));
        end
        model_resp = rd[3];
        if_req = 1'b1;
        dm_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_done(10, seen, sc, ic);
            n_checks++;
            if (!(seen && if_done === (k % 2 == 0) && dm_done === (k % 2 == 1)))
                $display("FAIL grant_order_%0d: got seen=%0d ifd=%b dmd=%b expected %s",
                         k, seen, if_done, dm_done, (k % 2 == 0) ? "fetch" : "data");
            else n_pass++;
            readdata = rd[k + 1];
            if (k == 3) begin
                if_req = 1'b0;
                dm_req = 1'b0;
            end
        end
        step();
        n_checks++;
        if (both_done_err != 0) $display("FAIL both_done: got %0d cycles expected 0", both_done_err);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (act_q.size() == 0) $display("FAIL sb_rr: got nothing expected %h", e);
            else begin
                a = act_q.pop_front();
                if (a !== e) $display("FAIL sb_rr: got %h expected %h", a, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_store();
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        bit            seen;
        int            sc;
        int            ic;
        stall_target  = 1;
        readdata      = 32'h5A5A_5A5A;
        dm_write      = 1'b1;
        dm_addr       = 32'h0000_1000;
        dm_wdata      = 32'hDEAD_BEEF;
        dm_byteenable = 4'b0011;
        dm_req        = 1'b1;
        exp_q.push_back(pack_txn(K_STORE, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, model_resp));
        step();
        n_checks++;
        if (!(write === 1'b1 && read === 1'b0 && address === 32'h0000_1000 &&
              writedata === 32'hDEAD_BEEF && byteenable === 4'b0011))
            $display("FAIL store_strobe: got w=%b r=%b a=%h wd=%h be=%b expected w=1 r=0 a=00001000 wd=deadbeef be=0011",
                     write, read, address, writedata, byteenable);
        else n_pass++;
        wait_done(10, seen, sc, ic);
        dm_req   = 1'b0;
        dm_write = 1'b0;
        n_checks++;
        if (!(seen && dm_done === 1'b1 && if_done === 1'b0 && resp_rdata === model_resp))
            $display("FAIL store_done: got seen=%0d dmd=%b rdata=%h expected seen=1 dmd=1 rdata=%h",
                     seen, dm_done, resp_rdata, model_resp);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (act_q.size() == 0) $display("FAIL sb_store: got nothing expected %h", e);
            else begin
                a = act_q.pop_front();
                if (a !== e) $display("FAIL sb_store: got %h expected %h", a, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        logic [1:0]    kind;
        logic [31:0]   addr;
        logic [31:0]   wd;
        logic [31:0]   rd;
        logic [3:0]    be;
        int            stall;
        bit            seen;
        int            sc;
        int            ic;
        for (int i = 0; i < 6; i++) begin
            kind  = 2'($urandom_range(0, 2));
            stall = $urandom_range(0, 3);
            addr  = $urandom() & 32'hFFFF_FFFC;
            wd    = $urandom();
            rd    = $urandom();
            be    = 4'($urandom_range(1, 15));
            stall_target = stall;
            readdata     = rd;
            if (kind == K_FETCH) begin
                if_addr = addr;
                if_req  = 1'b1;
                dm_req  = 1'b0;
                model_resp = rd;
                exp_q.push_back(pack_txn(K_FETCH, addr, 32'h0, 4'hF, rd));
            end else begin
                dm_addr       = addr;
                dm_wdata      = wd;
                dm_byteenable = be;
                dm_write      = (kind == K_STORE);
                dm_req        = 1'b1;
                if_req        = 1'b0;
                if (kind == K_LOAD) model_resp = rd;
                exp_q.push_back(pack_txn(kind, addr, wd, be, model_resp));
            end
            wait_done(stall + 6, seen, sc, ic);
            n_checks++;
            if (!(seen && sc == stall + 1 && ic == 0))
                $display("FAIL b2b_latency_%0d: got seen=%0d strobes=%0d idle=%0d expected seen=1 strobes=%0d idle=0",
                         i, seen, sc, ic, stall + 1);
            else n_pass++;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (act_q.size() == 0) $display("FAIL sb_b2b_%0d: got nothing expected %h", i, e);
                else begin
                    a = act_q.pop_front();
                    if (a !== e) $display("FAIL sb_b2b_%0d: got %h expected %h", i, a, e);
                    else n_pass++;
                end
            end
        end
        if_req   = 1'b0;
        dm_req   = 1'b0;
        dm_write = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        logic [31:0]   rd;
        bit            seen;
        int            sc;
        int            ic;
        int            d0;
        stall_target = 1000;
        if_addr      = 32'h0040_0020;
        if_req       = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < MID_STALL; i++) step();
        n_checks++;
        if (!(read === 1'b1 && address === 32'h0040_0020 && done_cnt == d0 && bus_err === 1'b0))
            $display("FAIL stall_hold: got r=%b a=%h pulses=%0d err=%b expected r=1 a=00400020 pulses=0 err=0",
                     read, address, done_cnt - d0, bus_err);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (!(read === 1'b0 && address === 32'h0 && resp_rdata === 32'h0))
            $display("FAIL async_reset: got r=%b a=%h rdata=%h expected r=0 a=0 rdata=0",
                     read, address, resp_rdata);
        else n_pass++;
        if_req = 1'b0;
        step();
        step();
        reset        = 1'b0;
        model_resp   = '0;
        stall_target = 0;
        step();
        step();
        n_checks++;
        if (done_cnt != d0 || act_q.size() != 0)
            $display("FAIL reset_no_done: got %0d pulses expected 0", done_cnt - d0);
        else n_pass++;
        rd       = $urandom();
        readdata = rd;
        if_addr  = 32'hBFC0_0004;
        if_req   = 1'b1;
        exp_q.push_back(pack_txn(K_FETCH, 32'hBFC0_0004, 32'h0, 4'hF, rd));
        model_resp = rd;
        wait_done(10, seen, sc, ic);
        if_req = 1'b0;
        n_checks++;
        if (!(seen && sc == 1 && resp_rdata === rd))
            $display("FAIL post_reset_fetch: got seen=%0d strobes=%0d rdata=%h expected seen=1 strobes=1 rdata=%h",
                     seen, sc, resp_rdata, rd);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (act_q.size() == 0) $display("FAIL sb_post_reset: got nothing expected %h", e);
            else begin
                a = act_q.pop_front();
                if (a !== e) $display("FAIL sb_post_reset: got %h expected %h", a, e);
                else n_pass++;
            end
        end
        step();
    endtask

`ifdef MIPS_BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        bit            seen;
        int            sc;
        int            ic;
        stall_target = 1000;
        readdata     = 32'h1234_5678;
        if_addr      = 32'h0000_8000;
        if_req       = 1'b1;
        exp_q.push_back(pack_txn(K_FETCH, 32'h0000_8000, 32'h0, 4'hF, 32'h0));
        model_resp = '0;
        wait_done(40, seen, sc, ic);
        if_req = 1'b0;
        n_checks++;
        if (!(seen && sc == TIMEOUT_CYCLES && bus_err === 1'b1 && if_done === 1'b1 &&
              resp_rdata === 32'h0 && read === 1'b0))
            $display("FAIL timeout_abort: got seen=%0d strobes=%0d err=%b ifd=%b rdata=%h r=%b expected 1/%0d/1/1/0/0",
                     seen, sc, bus_err, if_done, resp_rdata, read, TIMEOUT_CYCLES);
        else n_pass++;
        step();
        n_checks++;
        if (bus_err !== 1'b0) $display("FAIL timeout_err_pulse: got err=%b expected 0", bus_err);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (act_q.size() == 0) $display("FAIL sb_timeout: got nothing expected %h", e);
            else begin
                a = act_q.pop_front();
                if (a !== e) $display("FAIL sb_timeout: got %h expected %h", a, e);
                else n_pass++;
            end
        end
        stall_target = 0;
    endtask
`endif

    task automatic test_invariants();
        n_checks++;
        if (rw_err != 0 || both_done_err != 0 || width_err != 0 || stable_err != 0)
            $display("FAIL invariants: got rw=%0d both=%0d width=%0d stable=%0d expected all 0",
                     rw_err, both_done_err, width_err, stable_err);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0 || act_q.size() != 0)
            $display("FAIL sb_leftover: got exp=%0d act=%0d expected 0/0", exp_q.size(), act_q.size());
        else n_pass++;
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_fetch_no_wait();
        test_wait_states();
        test_simultaneous();
        test_store();
        test_back_to_back();
        test_reset_mid();
`ifdef MIPS_BUS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_invariants();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
